// File: rtl/cga_vram_wr.sv
// CPU-side VRAM access port for the CGA block. CPU writes are posted into a
// small FIFO; writes and reads reach VRAM only in sequencer-granted CPU slots,
// and a pending read is issued only once all earlier writes have drained.
module cga_vram_wr #(
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     bus_wr,
  input  logic                     bus_rd,
  input  logic [ADDR_W-1:0]        bus_addr,
  input  logic [7:0]               bus_din,
  output logic [7:0]               bus_dout,
  output logic                     bus_rdy,
  output logic                     wr_full,
  output logic                     wr_overflow,
  output logic [$clog2(DEPTH):0]   fifo_count,
  input  logic                     cpu_slot,
  output logic [ADDR_W-1:0]        vram_addr,
  output logic [7:0]               vram_dout,
  output logic                     vram_we,
  output logic                     vram_oe,
  input  logic [7:0]               vram_din
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, WR, RD, CAP} state_t;

  state_t              state;
  logic [ADDR_W+7:0]   mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;
  logic                rd_pend;
  logic [ADDR_W-1:0]   rd_addr;
  logic                push;
  logic                pop;

  // Full is judged on the current count, before any same-cycle pop.
  always_comb begin
    wr_full = (count == DEPTH_C);
    push    = bus_wr && !wr_full;
    pop     = cpu_slot && (state == IDLE) && (count != '0);
  end

  assign fifo_count = count;

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus_addr, bus_din};
  end

  // FIFO bookkeeping, read request capture and slot-driven access sequencer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      wr_overflow <= 1'b0;
      rd_pend     <= 1'b0;
      rd_addr     <= '0;
      bus_rdy     <= 1'b1;
      bus_dout    <= '0;
      vram_addr   <= '0;
      vram_dout   <= '0;
      vram_we     <= 1'b0;
      vram_oe     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (bus_wr && wr_full) wr_overflow <= 1'b1;

      // bus_rdy is low whenever a read is pending or in service, so this
      // never collides with the IDLE/CAP updates below.
      if (bus_rd && bus_rdy) begin
        rd_pend <= 1'b1;
        rd_addr <= bus_addr;
        bus_rdy <= 1'b0;
      end

      vram_we <= 1'b0;
      vram_oe <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_slot) begin
            if (count != '0) begin
              vram_we   <= 1'b1;
              vram_addr <= mem[rd_ptr][ADDR_W+7:8];
              vram_dout <= mem[rd_ptr][7:0];
              state     <= WR;
            end else if (rd_pend) begin
              vram_oe   <= 1'b1;
              vram_addr <= rd_addr;
              rd_pend   <= 1'b0;
              state     <= RD;
            end
          end
        end
        WR:      state <= IDLE;
        RD:      state <= CAP;
        CAP: begin
          bus_dout <= vram_din;
          bus_rdy  <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cga_vram_wr.sv
// Scoreboard bench for cga_vram_wr: a transaction-level model predicts VRAM
// strobes and read returns; a negedge monitor compares against the DUT.
module tb_cga_vram_wr;
  localparam int ADDR_W = 14;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n = 1'b0;
  logic              bus_wr = 1'b0, bus_rd = 1'b0, cpu_slot = 1'b0;
  logic [ADDR_W-1:0] bus_addr = '0;
  logic [7:0]        bus_din = '0;
  logic [7:0]        bus_dout;
  logic              bus_rdy, wr_full, wr_overflow;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [ADDR_W-1:0] vram_addr;
  logic [7:0]        vram_dout;
  logic              vram_we, vram_oe;
  logic [7:0]        vram_din = '0;

  cga_vram_wr #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus_wr(bus_wr), .bus_rd(bus_rd),
    .bus_addr(bus_addr), .bus_din(bus_din), .bus_dout(bus_dout),
    .bus_rdy(bus_rdy), .wr_full(wr_full), .wr_overflow(wr_overflow),
    .fifo_count(fifo_count), .cpu_slot(cpu_slot), .vram_addr(vram_addr),
    .vram_dout(vram_dout), .vram_we(vram_we), .vram_oe(vram_oe),
    .vram_din(vram_din)
  );

  // Behavioural VRAM: data returned the cycle after vram_oe, junk otherwise.
  logic [7:0] rmem [1<<ADDR_W];
  always @(posedge clk) begin
    if (vram_we) rmem[vram_addr] <= vram_dout;
    if (vram_oe) vram_din <= rmem[vram_addr];
    else         vram_din <= 8'($urandom);
  end

  typedef struct { int cyc; bit is_rd; logic [ADDR_W-1:0] addr; logic [7:0] data; } ev_t;
  typedef struct { int cyc; logic [7:0] data; } rd_t;
  ev_t exp_ev[$];
  rd_t exp_rd[$];

  // Reference model: FIFO as a queue, VRAM as an array, engine busy-until time.
  logic [ADDR_W+7:0] mq[$];
  logic [7:0]        mmem [1<<ADDR_W];
  bit                m_pend, m_busy_rd, m_rdy = 1'b1, m_ovf;
  int                m_rdy_at, m_free_at;
  logic [7:0]        m_rd_data, m_dout;
  logic [ADDR_W-1:0] m_rd_addr;

  int   e_count;
  bit   e_full, e_ovf, e_rdy;
  logic [7:0] e_dout;
  bit   chk_en = 1'b0;
  int   cyc = 0;
  int   tests = 0, fails = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // One clock of stimulus; the model advances across the same edge.
  task automatic step(bit rst, bit wr, bit rd, logic [ADDR_W-1:0] a, logic [7:0] d, bit slot);
    logic [ADDR_W+7:0] w;
    bit full_now, pend_now, rdy_now;
    @(posedge clk); #1;
    cyc++;
    if (m_busy_rd && cyc == m_rdy_at) begin
      m_rdy = 1'b1; m_dout = m_rd_data; m_busy_rd = 1'b0;
    end
    e_count = mq.size(); e_full = (mq.size() == DEPTH);
    e_ovf = m_ovf; e_rdy = m_rdy; e_dout = m_dout;
    rst_n = !rst; bus_wr = wr; bus_rd = rd; bus_addr = a; bus_din = d; cpu_slot = slot;
    if (rst) begin
      mq.delete();
      m_pend = 0; m_busy_rd = 0; m_rdy = 1; m_ovf = 0; m_dout = '0;
      m_free_at = cyc + 1;
      while (exp_ev.size() > 0 && exp_ev[$].cyc > cyc) void'(exp_ev.pop_back());
      while (exp_rd.size() > 0 && exp_rd[$].cyc > cyc) void'(exp_rd.pop_back());
    end else begin
      full_now = (mq.size() == DEPTH);
      pend_now = m_pend;
      rdy_now  = m_rdy;
      if (slot && cyc >= m_free_at) begin
        if (mq.size() > 0) begin
          w = mq.pop_front();
          exp_ev.push_back('{cyc + 1, 1'b0, w[ADDR_W+7:8], w[7:0]});
          mmem[w[ADDR_W+7:8]] = w[7:0];
          m_free_at = cyc + 2;
        end else if (pend_now) begin
          exp_ev.push_back('{cyc + 1, 1'b1, m_rd_addr, 8'h00});
          m_pend = 0; m_busy_rd = 1; m_rdy_at = cyc + 3;
          m_rd_data = mmem[m_rd_addr];
          exp_rd.push_back('{cyc + 3, m_rd_data});
          m_free_at = cyc + 3;
        end
      end
      if (wr) begin
        if (!full_now) mq.push_back({a, d});
        else m_ovf = 1;
      end
      if (rd && rdy_now) begin
        m_pend = 1; m_rd_addr = a; m_rdy = 0;
      end
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, 0);
  endtask

  task automatic check_reset_outs();
    check("rst_vram_addr", 32'(vram_addr), 32'h0);
    check("rst_vram_dout", 32'(vram_dout), 32'h0);
    check("rst_vram_we",   32'(vram_we),   32'h0);
    check("rst_vram_oe",   32'(vram_oe),   32'h0);
  endtask

  // Monitor: per-cycle status against the model, strobes and reads via queues.
  initial begin : monitor
    ev_t ev;
    rd_t r;
    bit prev_rdy = 1'b1;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("fifo_count",  32'(fifo_count),  32'(e_count));
        check("wr_full",     32'(wr_full),     32'(e_full));
        check("wr_overflow", 32'(wr_overflow), 32'(e_ovf));
        check("bus_rdy",     32'(bus_rdy),     32'(e_rdy));
        check("bus_dout",    32'(bus_dout),    32'(e_dout));
        check("we_oe_excl",  32'(vram_we & vram_oe), 32'h0);
        if (vram_we || vram_oe) begin
          if (exp_ev.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_strobe at cycle %0d: got we=%0b oe=%0b addr=%0h expected none",
                     cyc, vram_we, vram_oe, vram_addr);
          end else begin
            ev = exp_ev.pop_front();
            check("strobe_cycle", 32'(cyc), 32'(ev.cyc));
            check("strobe_kind",  32'(vram_oe), 32'(ev.is_rd));
            check("vram_addr",    32'(vram_addr), 32'(ev.addr));
            if (!ev.is_rd) check("vram_dout", 32'(vram_dout), 32'(ev.data));
          end
        end else if (exp_ev.size() > 0 && exp_ev[0].cyc < cyc) begin
          ev = exp_ev.pop_front();
          tests++; fails++;
          $display("FAIL missing_strobe at cycle %0d: got none expected %s addr=%0h at cycle %0d",
                   cyc, ev.is_rd ? "read" : "write", ev.addr, ev.cyc);
        end
        if (bus_rdy && !prev_rdy && exp_rd.size() > 0) begin
          r = exp_rd.pop_front();
          check("rd_ready_cycle", 32'(cyc), 32'(r.cyc));
          check("rd_data",        32'(bus_dout), 32'(r.data));
        end else if (exp_rd.size() > 0 && exp_rd[0].cyc < cyc) begin
          r = exp_rd.pop_front();
          tests++; fails++;
          $display("FAIL missing_read_return at cycle %0d: got none expected data %0h at cycle %0d",
                   cyc, r.data, r.cyc);
        end
        prev_rdy = bus_rdy;
      end
    end
  end

  logic [ADDR_W-1:0] aset [8] = '{14'h0000, 14'h0001, 14'h3FFF, 14'h0123,
                                  14'h0100, 14'h2000, 14'h1555, 14'h3FFE};

  initial begin : stim
    for (int i = 0; i < (1 << ADDR_W); i++) begin rmem[i] = '0; mmem[i] = '0; end

    // Reset
    step(1, 0, 0, '0, '0, 0);
    chk_en = 1'b1;
    step(1, 0, 0, '0, '0, 0);
    idle(1);
    check_reset_outs();

    // Three writes drained by widely spaced slots
    step(0, 1, 0, 14'h0000, 8'h41, 0);
    step(0, 1, 0, 14'h0001, 8'h07, 0);
    step(0, 1, 0, 14'h3FFF, 8'hFF, 0);
    for (int k = 0; k < 3; k++) begin idle(7); step(0, 0, 0, '0, '0, 1); end
    idle(4);

    // Five back-to-back writes without slots: fifth overflows
    for (int k = 0; k < 5; k++) step(0, 1, 0, 14'(14'h0100 + k), 8'(8'h10 + k), 0);
    idle(3);
    for (int k = 0; k < 4; k++) begin step(0, 0, 0, '0, '0, 1); idle(2); end
    idle(3);

    // Write and read of the same address in one cycle
    step(0, 1, 1, 14'h0123, 8'hAA, 0);
    idle(2);
    step(0, 0, 0, '0, '0, 1);
    idle(2);
    step(0, 0, 0, '0, '0, 1);
    idle(5);

    // Read with empty FIFO; second read while busy is ignored
    step(0, 0, 1, 14'h0001, 8'h00, 0);
    idle(1);
    step(0, 0, 0, '0, '0, 1);
    step(0, 0, 1, 14'h3FFF, 8'h00, 0);
    idle(4);
    for (int k = 0; k < 3; k++) begin step(0, 0, 0, '0, '0, 1); idle(2); end

    // Push at full coincident with a pop
    step(1, 0, 0, '0, '0, 0);
    for (int k = 0; k < 4; k++) step(0, 1, 0, 14'(14'h2000 + k), 8'(8'hC0 + k), 0);
    step(0, 1, 0, 14'h0200, 8'h55, 1);
    idle(1);
    for (int k = 0; k < 4; k++) begin step(0, 0, 0, '0, '0, 1); idle(1); end
    idle(2);

    // Reset during the capture cycle with two writes queued
    step(0, 0, 1, 14'h0100, 8'h00, 0);
    idle(1);
    step(0, 1, 0, 14'h0222, 8'h22, 1);
    step(0, 1, 0, 14'h0333, 8'h33, 0);
    step(1, 0, 0, '0, '0, 0);
    idle(1);
    check_reset_outs();
    for (int k = 0; k < 3; k++) begin step(0, 0, 0, '0, '0, 1); idle(1); end

    // Randomized traffic
    for (int k = 0; k < 4000; k++) begin
      step(($urandom_range(0, 599) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0),
           aset[$urandom_range(0, 7)],
           8'($urandom),
           ($urandom_range(0, 2) == 0));
    end

    // Drain whatever is left
    for (int k = 0; k < 12; k++) begin step(0, 0, 0, '0, '0, 1); idle(3); end
    idle(4);
    check("leftover_strobes", 32'(exp_ev.size()), 32'h0);
    check("leftover_reads",   32'(exp_rd.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cga_vram_wr.md
Name: cga_vram_wr

Overview:
- CPU-side VRAM access port for the CGA video block; the write/read end of the same video RAM that the display path fetches from.
- Posts CPU bus writes into a small FIFO.
- Issues writes and CPU reads to VRAM only in CPU access slots granted by the clock sequencer, so display character/attribute fetches are never disturbed.
- Read-after-write coherence: a pending read waits until all earlier posted writes have drained.

Parameters:
- ADDR_W, 14, VRAM address width.
- DEPTH, 4, write FIFO entries; power of two, 2 to 16.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- bus_wr  in  1  one-cycle CPU write request.
- bus_rd  in  1  one-cycle CPU read request.
- bus_addr  in  ADDR_W  CPU address, sampled with bus_wr/bus_rd.
- bus_din  in  8  CPU write data, sampled with bus_wr.
- bus_dout  out  8  read data; valid when bus_rdy rises after a read.
- bus_rdy  out  1  high = no read in flight.
- wr_full  out  1  FIFO count == DEPTH.
- wr_overflow  out  1  sticky; set when bus_wr is rejected.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy.
- cpu_slot  in  1  one-cycle pulse from sequencer: VRAM free next cycle.
- vram_addr  out  ADDR_W  VRAM address, registered.
- vram_dout  out  8  VRAM write data, registered.
- vram_we  out  1  VRAM write strobe, one cycle, registered.
- vram_oe  out  1  VRAM read strobe, one cycle, registered.
- vram_din  in  8  VRAM read data, valid the cycle after vram_oe.

Behaviour:
- Reset (rst_n low at a clk edge):
  - FIFO emptied; fifo_count=0, wr_full=0, wr_overflow=0.
  - vram_we=0, vram_oe=0, vram_addr=0, vram_dout=0.
  - bus_dout=0, bus_rdy=1, state IDLE.
  - Any read in flight is discarded; no further strobes are issued for it.
- Push:
  - bus_wr with count<DEPTH stores {bus_addr, bus_din} at the tail.
  - Full is evaluated before any same-cycle pop: bus_wr at count==DEPTH is rejected even if a pop occurs that cycle.
  - A rejected write sets wr_overflow, which is cleared only by reset.
- Read request:
  - bus_rd while bus_rdy=1 latches bus_addr; bus_rdy goes 0 the next cycle.
  - bus_rd while bus_rdy=0 is ignored.
  - bus_rd and bus_wr in the same cycle: the write is pushed first and the read is ordered after it, so it returns the new data.
- State machine, advanced on cpu_slot:
  - IDLE: on cpu_slot, FIFO non-empty takes priority: pop the head and go to WR. Otherwise, if a read is pending, go to RD. Otherwise stay in IDLE.
  - WR (one cycle): vram_we=1, vram_addr/vram_dout = popped entry. Return to IDLE.
  - RD (one cycle): vram_oe=1, vram_addr = read address. Go to CAP.
  - CAP (one cycle): bus_dout <= vram_din. Go to IDLE. bus_rdy=1 from the following cycle.
- Timing: cpu_slot at cycle N gives a strobe at N+1. Read data is captured at the end of N+2. bus_rdy is high at N+3.
- Ordering and throughput:
  - A pending read is serviced only when the FIFO is empty at a cpu_slot.
  - Writes pushed while a read waits still drain first; software keeps bus_wr quiet while bus_rdy=0.
  - cpu_slot arriving in WR, RD or CAP is ignored (no queueing). At most one VRAM access per slot.
- Strobes: vram_we and vram_oe are never high together, and each is high for at most one cycle. vram_addr and vram_dout hold their last value while idle.
- FIFO pointers: wrap modulo DEPTH. fifo_count changes by +1, -1, or 0 for a simultaneous push and pop.

Test Plan:
- Reset, then 3 writes (0x0000=41, 0x0001=07, 0x3FFF=FF) with cpu_slot every 8 cycles -> exactly 3 vram_we pulses in order with matching addr/data, each one cycle after a slot; fifo_count 3→0.
- 5 writes back-to-back with no slots -> first 4 accepted, wr_full=1, 5th rejected, wr_overflow=1 and stays 1; the 4 drain in order once slots resume.
- Write 0x0123=AA, then bus_rd 0x0123 in the same cycle -> vram_we precedes vram_oe; with vram_din=AA, bus_dout=AA, bus_rdy high 3 cycles after the read's slot.
- bus_rd with empty FIFO, cpu_slot at N -> vram_oe at N+1, capture at N+2, bus_rdy=1 at N+3; a second bus_rd while bus_rdy=0 produces no extra vram_oe.
- Push at count==DEPTH coincident with a pop -> push rejected, count becomes DEPTH-1, wr_overflow=1.
- rst_n low for one cycle during CAP with 2 entries queued -> all outputs at reset values, no further strobes, bus_rdy=1, fifo_count=0.
